// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Provides the FSM state encoding and the round-robin mask generator.
package wrr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int unsigned MASK_MAX_W = 64;

  // Ones strictly above idx, limited to the low n bits; zero when idx is the top index.
  function automatic logic [MASK_MAX_W-1:0] mask_after(input int unsigned idx, input int unsigned n);
    logic [MASK_MAX_W-1:0] ones_v;
    ones_v = '1;
    return (ones_v << (idx + 32'd1)) & ~(ones_v << n);
  endfunction

endpackage

// File: rtl/wrr_arb_lsb_pick.sv
// Combinational lowest-set-bit picker: returns a one-hot vector of the
// least significant set bit of req, or zero when req is zero.
module lsb_pick
  import wrr_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] pick
);

  assign pick = req & (~req + {{(N-1){1'b0}}, 1'b1});

endmodule

// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter with registered one-hot grant; a winner keeps
// the grant for up to weight+1 accepted beats before it rotates onward.
module wrr_arb
  import wrr_arb_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int WGT_W = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       req_i,
  input  logic [N*WGT_W-1:0] weight_i,
  input  logic               beat_i,
  output logic [N-1:0]       gnt_o,
  output logic               gnt_vld_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic [WGT_W-1:0]   credit_o
);

  state_e            state_r;
  logic [N-1:0]      gnt_r;
  logic [N-1:0]      mask_r;
  logic              gnt_vld_r;
  logic [IDX_W-1:0]  idx_r;
  logic [WGT_W-1:0]  credit_r;

  logic [N-1:0]      masked_s;
  logic [N-1:0]      pick_m_s;
  logic [N-1:0]      pick_r_s;
  logic [N-1:0]      pick_s;
  logic [N-1:0]      next_mask_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic [WGT_W-1:0]  wgt_s [N];
  logic [WGT_W-1:0]  pick_wgt_s;
  logic              any_req_s;
  logic              release_s;

  assign masked_s = req_i & mask_r;

  lsb_pick #(.N(N)) u_pick_masked (
    .req  (masked_s),
    .pick (pick_m_s)
  );

  lsb_pick #(.N(N)) u_pick_raw (
    .req  (req_i),
    .pick (pick_r_s)
  );

  // Unpack the flat weight bus into per-requester fields.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wgt_s[i] = weight_i[i*WGT_W +: WGT_W];
    end
  end

  // Round-robin pick, its index, weight and the mask that follows it; release decision.
  always_comb begin
    pick_s     = {N{1'b0}};
    pick_idx_s = {IDX_W{1'b0}};
    if (|masked_s) begin
      pick_s = pick_m_s;
    end else begin
      pick_s = pick_r_s;
    end
    for (int i = 0; i < N; i++) begin
      pick_idx_s = pick_idx_s | (pick_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
    pick_wgt_s  = wgt_s[pick_idx_s];
    next_mask_s = N'(mask_after(32'(pick_idx_s), 32'(N)));
    any_req_s   = |req_i;
    // Only the current holder's request and the beat/credit pair can end a grant.
    release_s   = !req_i[idx_r] || (beat_i && (credit_r == {WGT_W{1'b0}}));
  end

  // Grant FSM with credit counter and rotating priority mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      gnt_r     <= {N{1'b0}};
      gnt_vld_r <= 1'b0;
      idx_r     <= {IDX_W{1'b0}};
      credit_r  <= {WGT_W{1'b0}};
      mask_r    <= {N{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r   <= GRANT;
            gnt_r     <= pick_s;
            gnt_vld_r <= 1'b1;
            idx_r     <= pick_idx_s;
            credit_r  <= pick_wgt_s;
            mask_r    <= next_mask_s;
          end
        end
        GRANT: begin
          if (release_s && any_req_s) begin
            gnt_r     <= pick_s;
            gnt_vld_r <= 1'b1;
            idx_r     <= pick_idx_s;
            credit_r  <= pick_wgt_s;
            mask_r    <= next_mask_s;
          end else if (release_s) begin
            state_r   <= IDLE;
            gnt_r     <= {N{1'b0}};
            gnt_vld_r <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            credit_r  <= {WGT_W{1'b0}};
          end else if (beat_i) begin
            credit_r  <= credit_r - WGT_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          gnt_r     <= {N{1'b0}};
          gnt_vld_r <= 1'b0;
          idx_r     <= {IDX_W{1'b0}};
          credit_r  <= {WGT_W{1'b0}};
          mask_r    <= {N{1'b0}};
        end
      endcase
    end
  end

  assign gnt_o     = gnt_r;
  assign gnt_vld_o = gnt_vld_r;
  assign gnt_idx_o = idx_r;
  assign credit_o  = credit_r;

endmodule

// File: tb/tb_wrr_arb.sv
// Directed scoreboard bench for wrr_arb (N=4, WGT_W=3): expectations are queued
// as stimulus is applied and popped when the registered outputs are sampled.
module tb_wrr_arb;

  localparam int N     = 4;
  localparam int WGT_W = 3;
  localparam int IDX_W = 2;

  logic               clk;
  logic               reset_n;
  logic [N-1:0]       req_i;
  logic [N*WGT_W-1:0] weight_i;
  logic               beat_i;
  logic [N-1:0]       gnt_o;
  logic               gnt_vld_o;
  logic [IDX_W-1:0]   gnt_idx_o;
  logic [WGT_W-1:0]   credit_o;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] idx;
    logic [2:0] credit;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  wrr_arb #(.N(N), .WGT_W(WGT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req_i),
    .weight_i  (weight_i),
    .beat_i    (beat_i),
    .gnt_o     (gnt_o),
    .gnt_vld_o (gnt_vld_o),
    .gnt_idx_o (gnt_idx_o),
    .credit_o  (credit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] wv(input logic [2:0] w0, input logic [2:0] w1,
                                     input logic [2:0] w2, input logic [2:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] i,
                            input logic [2:0] c);
    exp_t e;
    e.tag    = tag;
    e.gnt    = g;
    e.vld    = |g;
    e.idx    = i;
    e.credit = c;
    sb_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty got 0 entries exp >=1");
    end else begin
      e = sb_q.pop_front();
      checks++;
      assert (gnt_o === e.gnt) else begin
        errors++;
        $error("FAIL %s gnt_o got %b exp %b", e.tag, gnt_o, e.gnt);
      end
      checks++;
      assert (gnt_vld_o === e.vld) else begin
        errors++;
        $error("FAIL %s gnt_vld_o got %b exp %b", e.tag, gnt_vld_o, e.vld);
      end
      checks++;
      assert (gnt_idx_o === e.idx) else begin
        errors++;
        $error("FAIL %s gnt_idx_o got %0d exp %0d", e.tag, gnt_idx_o, e.idx);
      end
      checks++;
      assert (credit_o === e.credit) else begin
        errors++;
        $error("FAIL %s credit_o got %0d exp %0d", e.tag, credit_o, e.credit);
      end
    end
  endtask

  // Apply inputs, queue the outputs expected after the next edge, then sample.
  task automatic step(input string tag, input logic [3:0] req, input logic beat,
                      input logic [3:0] g, input logic [1:0] i, input logic [2:0] c);
    req_i  = req;
    beat_i = beat;
    expect_out(tag, g, i, c);
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    reset_n  = 1'b1;
    req_i    = 4'b1111;
    weight_i = 12'd0;
    beat_i   = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    expect_out("rst_async", 4'b0000, 2'd0, 3'd0);
    check_now();
    step("rst_hold", 4'b1111, 1'b0, 4'b0000, 2'd0, 3'd0);

    // 1: first grant one cycle after request, then asynchronous reset mid-grant
    reset_n  = 1'b1;
    weight_i = wv(3'd2, 3'd0, 3'd0, 3'd0);
    step("t1_first", 4'b0101, 1'b0, 4'b0001, 2'd0, 3'd2);
    step("t1_hold",  4'b0101, 1'b0, 4'b0001, 2'd0, 3'd2);
    #2 reset_n = 1'b0;
    #1;
    expect_out("t1_midrst", 4'b0000, 2'd0, 3'd0);
    check_now();
    step("t1_inrst", 4'b0101, 1'b0, 4'b0000, 2'd0, 3'd0);
    reset_n = 1'b1;

    // 2: equal weights rotate one beat each
    weight_i = 12'd0;
    step("t2_g0",   4'b1111, 1'b1, 4'b0001, 2'd0, 3'd0);
    step("t2_g1",   4'b1111, 1'b1, 4'b0010, 2'd1, 3'd0);
    step("t2_g2",   4'b1111, 1'b1, 4'b0100, 2'd2, 3'd0);
    step("t2_g3",   4'b1111, 1'b1, 4'b1000, 2'd3, 3'd0);
    step("t2_wrap", 4'b1111, 1'b1, 4'b0001, 2'd0, 3'd0);

    // 3: weight 3 holds for four beats, sole requester re-wins via fallback
    weight_i = wv(3'd0, 3'd0, 3'd3, 3'd0);
    step("t3_c3",      4'b0100, 1'b1, 4'b0100, 2'd2, 3'd3);
    step("t3_c2",      4'b0100, 1'b1, 4'b0100, 2'd2, 3'd2);
    step("t3_c1",      4'b0100, 1'b1, 4'b0100, 2'd2, 3'd1);
    step("t3_c0",      4'b0100, 1'b1, 4'b0100, 2'd2, 3'd0);
    step("t3_regrant", 4'b0100, 1'b1, 4'b0100, 2'd2, 3'd3);

    // 4: withdrawal hands over without a bubble; no requesters gives idle
    step("t4_idle", 4'b0000, 1'b0, 4'b0000, 2'd0, 3'd0);
    weight_i = wv(3'd0, 3'd2, 3'd0, 3'd4);
    step("t4_g1",       4'b0010, 1'b0, 4'b0010, 2'd1, 3'd2);
    step("t4_withdraw", 4'b1000, 1'b0, 4'b1000, 2'd3, 3'd4);
    step("t4_to_idle",  4'b0000, 1'b0, 4'b0000, 2'd0, 3'd0);

    // 5: beats ignored when idle; weight sampled only at grant load
    step("t5_idle_beat_a", 4'b0000, 1'b1, 4'b0000, 2'd0, 3'd0);
    step("t5_idle_beat_b", 4'b0000, 1'b1, 4'b0000, 2'd0, 3'd0);
    weight_i = wv(3'd2, 3'd0, 3'd0, 3'd0);
    step("t5_g0", 4'b0001, 1'b0, 4'b0001, 2'd0, 3'd2);
    weight_i = wv(3'd5, 3'd0, 3'd0, 3'd0);
    step("t5_b1",      4'b0001, 1'b1, 4'b0001, 2'd0, 3'd1);
    step("t5_b2",      4'b0001, 1'b1, 4'b0001, 2'd0, 3'd0);
    step("t5_regrant", 4'b0001, 1'b1, 4'b0001, 2'd0, 3'd5);
    step("t5_c4",      4'b0001, 1'b1, 4'b0001, 2'd0, 3'd4);
    step("t5_c3",      4'b0001, 1'b1, 4'b0001, 2'd0, 3'd3);
    step("t5_c2",      4'b0001, 1'b1, 4'b0001, 2'd0, 3'd2);
    step("t5_c1",      4'b0001, 1'b1, 4'b0001, 2'd0, 3'd1);
    step("t5_c0",      4'b0001, 1'b1, 4'b0001, 2'd0, 3'd0);
    step("t5_next",    4'b0001, 1'b1, 4'b0001, 2'd0, 3'd5);

    // 6: final beat with request drop plus new lower request -> fallback handover
    weight_i = wv(3'd5, 3'd0, 3'd1, 3'd0);
    step("t6_drop_beat", 4'b0100, 1'b1, 4'b0100, 2'd2, 3'd1);
    step("t6_beat",      4'b0100, 1'b1, 4'b0100, 2'd2, 3'd0);
    step("t6_handover",  4'b0010, 1'b1, 4'b0010, 2'd1, 3'd0);
    step("t6_noise",     4'b1011, 1'b0, 4'b0010, 2'd1, 3'd0);
    step("t6_end",       4'b0000, 1'b0, 4'b0000, 2'd0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
